// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter examples (down_counter and the up-counter
// bench helpers).
//   DEFAULT_WIDTH : default counter / load-value width in bits
//   ST_IDLE/ST_RUN: state encoding of the down-counter control FSM
//   state_e       : enumerated state type built on that encoding
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN
  } state_e;

endpackage : counter_pkg

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Loadable down-counter / interval timer. A load captures a start value and
// starts the count (unless the value is zero). While enabled, the counter
// decrements toward zero and signals terminal count with a one-cycle o_done
// pulse. With auto-reload the start value is restored at terminal count so the
// block becomes a periodic tick source.
//
// Ports
//   i_clk          : clock, all logic on rising edge
//   i_reset_n      : synchronous active-low reset
//   i_load         : load strobe, captures i_load_value (beats counting)
//   i_load_value   : start / reload value (WIDTH bits)
//   i_enable       : count enable, low pauses the count
//   i_auto_reload  : 1 = reload at terminal count, 0 = stop at zero
//   o_count        : current counter value (registered)
//   o_busy         : high while running (decode of state)
//   o_zero         : high when o_count == 0 (decode of count)
//   o_done         : one-cycle pulse after terminal count (registered)
// -----------------------------------------------------------------------------
module down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  input  logic             i_auto_reload,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_zero,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] L_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] L_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  state_e           r_state;
  logic             r_done;

  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  state_e           w_state_nxt;
  logic             w_done_nxt;

  // Next-state logic: load has priority over counting; o_done defaults low.
  always_comb begin
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_state_nxt  = r_state;
    w_done_nxt   = 1'b0;

    if (i_load) begin
      w_count_nxt  = i_load_value;
      w_reload_nxt = i_load_value;
      // A zero load never starts a run, so it can never produce o_done.
      w_state_nxt  = (i_load_value != L_ZERO) ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_RUN: begin
          if (i_enable) begin
            if (r_count == L_ONE) begin
              // Terminal count; auto-reload is only looked at here.
              w_done_nxt = 1'b1;
              if (i_auto_reload) begin
                w_count_nxt = r_reload;
                w_state_nxt = S_RUN;
              end else begin
                w_count_nxt = L_ZERO;
                w_state_nxt = S_IDLE;
              end
            end else if (r_count == L_ZERO) begin
              // Unreachable by construction; recover to IDLE instead of wrapping.
              w_count_nxt = L_ZERO;
              w_state_nxt = S_IDLE;
            end else begin
              w_count_nxt = r_count - L_ONE;
            end
          end else begin
            w_count_nxt = r_count;
          end
        end
        default: begin
          w_count_nxt = L_ZERO;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count  <= L_ZERO;
      r_reload <= L_ZERO;
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_state  <= w_state_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign o_count = r_count;
  assign o_done  = r_done;
  assign o_busy  = (r_state == S_RUN);
  assign o_zero  = (r_count == L_ZERO);

endmodule : down_counter

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
// Directed bench for down_counter (WIDTH = 4). A behavioural reference model
// tracks the expected count, reload value, running flag and done pulse; a
// compare process checks all four outputs against it every cycle, and the
// directed sequence additionally checks hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_down_counter;

  localparam int W = 4;

  logic         i_clk;
  logic         i_reset_n;
  logic         i_load;
  logic [W-1:0] i_load_value;
  logic         i_enable;
  logic         i_auto_reload;
  logic [W-1:0] o_count;
  logic         o_busy;
  logic         o_zero;
  logic         o_done;

  int n_cmp;
  int n_bad;
  bit check_en;

  // Reference model state.
  int m_count;
  int m_reload;
  bit m_run;
  bit m_done;

  down_counter #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_load        (i_load),
    .i_load_value  (i_load_value),
    .i_enable      (i_enable),
    .i_auto_reload (i_auto_reload),
    .o_count       (o_count),
    .o_busy        (o_busy),
    .o_zero        (o_zero),
    .o_done        (o_done)
  );

  // Free-running clock, 10 time units period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: reset > load > count, done lasts one cycle after count 1.
  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      m_count  <= 0;
      m_reload <= 0;
      m_run    <= 1'b0;
      m_done   <= 1'b0;
    end else if (i_load) begin
      m_count  <= int'(i_load_value);
      m_reload <= int'(i_load_value);
      m_run    <= (i_load_value != 0);
      m_done   <= 1'b0;
    end else if (m_run && i_enable && m_count == 1) begin
      m_done <= 1'b1;
      if (i_auto_reload) begin
        m_count <= m_reload;
      end else begin
        m_count <= 0;
        m_run   <= 1'b0;
      end
    end else if (m_run && i_enable) begin
      m_count <= m_count - 1;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge i_clk) begin
    if (check_en) begin
      chk("model_count", 32'(o_count), 32'(m_count));
      chk("model_busy",  32'(o_busy),  32'(m_run));
      chk("model_zero",  32'(o_zero),  32'(m_count == 0));
      chk("model_done",  32'(o_done),  32'(m_done));
    end
  end

  // Advance past one rising edge and land on the following falling edge.
  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic expect_out(input string tag, input int cnt, input bit busy, input bit done);
    chk({tag, "_count"}, 32'(o_count), 32'(cnt));
    chk({tag, "_busy"},  32'(o_busy),  32'(busy));
    chk({tag, "_zero"},  32'(o_zero),  32'(cnt == 0));
    chk({tag, "_done"},  32'(o_done),  32'(done));
  endtask

  initial begin
    int exp_seq [6];
    int auto_seq [9];
    int done_at;
    n_cmp    = 0;
    n_bad    = 0;
    check_en = 1'b0;

    // Reset held 2 cycles while a load is also requested: reset wins.
    i_reset_n     = 1'b0;
    i_load        = 1'b1;
    i_load_value  = 4'd9;
    i_enable      = 1'b1;
    i_auto_reload = 1'b0;
    cyc();
    cyc();
    expect_out("reset", 0, 1'b0, 1'b0);
    i_reset_n = 1'b1;
    i_load    = 1'b0;
    check_en  = 1'b1;
    cyc();
    expect_out("after_reset", 0, 1'b0, 1'b0);

    // One-shot: load 5, enable high -> 5,4,3,2,1,0, done with the 0.
    exp_seq = '{5, 4, 3, 2, 1, 0};
    i_load = 1'b1; i_load_value = 4'd5; i_enable = 1'b1; i_auto_reload = 1'b0;
    cyc();
    i_load = 1'b0;
    expect_out("oneshot", exp_seq[0], 1'b1, 1'b0);
    for (int k = 1; k < 6; k++) begin
      cyc();
      expect_out("oneshot", exp_seq[k], (k != 5), (k == 5));
    end
    cyc();
    expect_out("oneshot_after", 0, 1'b0, 1'b0);

    // Auto-reload with 3: 3,2,1,3,2,1,... done at each reload, zero never high.
    auto_seq = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    i_load = 1'b1; i_load_value = 4'd3; i_auto_reload = 1'b1;
    cyc();
    i_load = 1'b0;
    expect_out("auto", 3, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      cyc();
      expect_out("auto", auto_seq[k], 1'b1, (auto_seq[k] == 3));
    end

    // Auto-reload with 1: done stays high continuously while enabled.
    i_load = 1'b1; i_load_value = 4'd1;
    cyc();
    i_load = 1'b0;
    expect_out("auto1_load", 1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      expect_out("auto1", 1, 1'b1, 1'b1);
    end

    // Pause: load 4, 2 enabled, 3 paused, then enabled -> done 7 edges after load.
    i_auto_reload = 1'b0;
    i_load = 1'b1; i_load_value = 4'd4; i_enable = 1'b1;
    cyc();
    i_load = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 9; k++) begin
      i_enable = !(k >= 3 && k <= 5);
      cyc();
      if (o_done === 1'b1 && done_at == 0) done_at = k;
    end
    chk("pause_done_edge", 32'(done_at), 32'd7);
    expect_out("pause_end", 0, 1'b0, 1'b0);
    i_enable = 1'b1;

    // Maximum value 15: done exactly after the 15th enabled edge.
    i_load = 1'b1; i_load_value = 4'd15;
    cyc();
    i_load = 1'b0;
    expect_out("max_load", 15, 1'b1, 1'b0);
    done_at = 0;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (o_done === 1'b1 && done_at == 0) done_at = k;
    end
    chk("max_done_edge", 32'(done_at), 32'd15);

    // Load 0: stays IDLE, no done.
    i_load = 1'b1; i_load_value = 4'd0;
    cyc();
    i_load = 1'b0;
    expect_out("load0", 0, 1'b0, 1'b0);
    cyc();
    expect_out("load0_hold", 0, 1'b0, 1'b0);

    // Load 7 on the terminal-count edge: load wins, no done.
    i_load = 1'b1; i_load_value = 4'd2;
    cyc();
    i_load = 1'b0;
    cyc();
    expect_out("coll_pre", 1, 1'b1, 1'b0);
    i_load = 1'b1; i_load_value = 4'd7;
    cyc();
    i_load = 1'b0;
    expect_out("coll_load", 7, 1'b1, 1'b0);
    cyc();
    expect_out("coll_next", 6, 1'b1, 1'b0);

    // Reset at count 1 with enable high: reset values, pending done suppressed.
    i_load = 1'b1; i_load_value = 4'd1;
    cyc();
    i_load = 1'b0;
    expect_out("rst_pre", 1, 1'b1, 1'b0);
    i_reset_n = 1'b0;
    cyc();
    i_reset_n = 1'b1;
    expect_out("rst_mid", 0, 1'b0, 1'b0);
    cyc();
    expect_out("rst_after", 0, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_down_counter
